// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
package mul_share_arbiter_pkg;

   // Arbiter sequencing states; encoding fixed at 2 bits.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Width of a requester index / round-robin pointer (at least one bit).
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_picker.sv
// Round-robin winner selection: first set request at or above rr_ptr, wrapping.
module rr_picker
   import mul_share_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = ptr_width(NREQ)
) (
   input  logic [NREQ-1:0] Req,
   input  logic [PW-1:0]   rr_ptr,
   output logic            Any,
   output logic [PW-1:0]   Win,
   output logic [NREQ-1:0] WinOneHot
);

   // Scan NREQ positions starting at rr_ptr; the first hit wins.
   always_comb begin
      int unsigned sum;
      logic [PW-1:0] idx;
      Any       = 1'b0;
      Win       = '0;
      WinOneHot = '0;
      sum       = 0;
      idx       = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         sum = 32'(rr_ptr) + i;
         if (sum >= NREQ) sum = sum - NREQ;
         idx = PW'(sum);
         if (!Any && Req[idx]) begin
            Any = 1'b1;
            Win = idx;
         end
      end
      if (Any) WinOneHot[Win] = 1'b1;
   end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one multi-cycle unsigned multiplier among NREQ requesters with
// round-robin arbitration and a Req/Gnt/Done handshake.
module mul_share_arbiter
   import mul_share_arbiter_pkg::*;
#(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DATAWIDTH = 32,
   parameter int unsigned MUL_LAT   = 3
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [NREQ-1:0]           Req,
   input  logic [NREQ*DATAWIDTH-1:0] A,
   input  logic [NREQ*DATAWIDTH-1:0] B,
   output logic [NREQ-1:0]           Gnt,
   output logic [NREQ-1:0]           Done,
   output logic [DATAWIDTH-1:0]      Prod,
   output logic                      Busy
);

   localparam int unsigned PW = ptr_width(NREQ);
   localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);

   state_t               state;
   logic [PW-1:0]        rr_ptr;
   logic [PW-1:0]        owner;
   logic [CW-1:0]        cnt;
   logic [DATAWIDTH-1:0] a_q;
   logic [DATAWIDTH-1:0] b_q;

   logic                 any;
   logic [PW-1:0]        win;
   logic [NREQ-1:0]      win_onehot;
   logic [PW-1:0]        rr_next;
   logic [NREQ-1:0]      owner_onehot;
   logic [DATAWIDTH-1:0] prod_next;
   logic [DATAWIDTH-1:0] a_arr [NREQ];
   logic [DATAWIDTH-1:0] b_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = A[g*DATAWIDTH +: DATAWIDTH];
      assign b_arr[g] = B[g*DATAWIDTH +: DATAWIDTH];
   end

   rr_picker #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_picker (
      .Req       (Req),
      .rr_ptr    (rr_ptr),
      .Any       (any),
      .Win       (win),
      .WinOneHot (win_onehot)
   );

   // Truncated unsigned product of the operands latched at grant.
   assign prod_next = a_q * b_q;
   assign rr_next   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

   // One-hot form of the current owner, used for the Done pulse.
   always_comb begin
      owner_onehot        = '0;
      owner_onehot[owner] = 1'b1;
   end

   // Arbiter FSM with registered handshake outputs and product.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= S_IDLE;
         rr_ptr <= '0;
         owner  <= '0;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         Gnt    <= '0;
         Done   <= '0;
         Prod   <= '0;
         Busy   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any) begin
                  a_q    <= a_arr[win];
                  b_q    <= b_arr[win];
                  owner  <= win;
                  Gnt    <= win_onehot;
                  cnt    <= CNT_INIT;
                  rr_ptr <= rr_next;
                  Busy   <= 1'b1;
                  state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  Prod  <= prod_next;
                  Done  <= owner_onehot;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               Done  <= '0;
               Gnt   <= '0;
               Busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
